// File: rtl/lane_dropper.sv
// lane_dropper: one key lane of the rhythm game. It spawns, moves, judges and retires falling notes.
// Optional feature macro LANE_DROPPER_EDGE_HIT_EN: only a fresh key press can score, so a held key hits at most once.
module lane_dropper #(
  parameter int          LANE_X       = 160,
  parameter logic [7:0]  KEYCODE      = 8'h07,
  parameter logic [7:0]  START_KEY    = 8'h2c,
  parameter logic [7:0]  RESTART_KEY  = 8'h01,
  parameter int          Y_START      = 100,
  parameter int          Y_MAX        = 400,
  parameter int          NOTE_H       = 40,
  parameter int          HIT_LO       = 340,
  parameter int          SPEED        = 1,
  parameter int          START_DELAY  = 760,
  parameter int          SPAWN_PERIOD = 120,
  parameter int          NUM_NOTES    = 8,
  parameter int          SLOTS        = 4
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          keycode,
  input  logic [7:0]          keycode_second,
  output logic [9:0]          dropX,
  output logic [10*SLOTS-1:0] dropY,
  output logic [SLOTS-1:0]    active,
  output logic                hit,
  output logic                miss,
  output logic [7:0]          hits,
  output logic [7:0]          combo,
  output logic                done,
  output logic [1:0]          state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [9:0]  Y_INIT        = 10'(Y_START);
  localparam logic [10:0] NOTE_H11      = 11'(NOTE_H);
  localparam logic [10:0] HIT_LO11      = 11'(HIT_LO);
  localparam logic [10:0] Y_MAX11       = 11'(Y_MAX);
  localparam logic [10:0] SPEED11       = 11'(SPEED);
  localparam logic [15:0] DELAY_LAST    = 16'(START_DELAY);
  localparam logic [15:0] PERIOD_RELOAD = 16'(SPAWN_PERIOD - 1);
  localparam logic [7:0]  NOTES8        = 8'(NUM_NOTES);

  logic [1:0]       state;
  logic [9:0]       slot_y [SLOTS];
  logic [15:0]      delay_cnt;
  logic [15:0]      period_cnt;
  logic [7:0]       spawned;
  logic             key_now;
  logic             key_ok;
  logic [10:0]      bottom [SLOTS];
  logic [SLOTS-1:0] in_window;
  logic [SLOTS-1:0] at_miss;
  logic [SLOTS-1:0] hit_oh;
  logic [SLOTS-1:0] miss_mask;
  logic [SLOTS-1:0] free_oh;
  logic             hit_found;
  logic             free_found;
  logic             any_miss;
  logic             spawn_due;
  logic [9:0]       best_y;

  assign dropX     = 10'(LANE_X);
  assign state_dbg = state;
  assign key_now   = (keycode == KEYCODE) || (keycode_second == KEYCODE);

`ifdef LANE_DROPPER_EDGE_HIT_EN
  logic key_prev;
  assign key_ok = key_now && !key_prev;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) key_prev <= 1'b0;
    else        key_prev <= key_now;
  end
`else
  assign key_ok = key_now;
`endif

  always_comb begin
    dropY = '0;
    for (int i = 0; i < SLOTS; i++) dropY[10*i +: 10] = slot_y[i];
  end

  // Judging works on pre-update Y; the deepest note in the window wins, ties to the lowest slot.
  always_comb begin
    bottom     = '{default: '0};
    in_window  = '0;
    at_miss    = '0;
    hit_found  = 1'b0;
    best_y     = '0;
    hit_oh     = '0;
    free_found = 1'b0;
    free_oh    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      bottom[i]    = {1'b0, slot_y[i]} + NOTE_H11;
      in_window[i] = active[i] && (bottom[i] >= HIT_LO11) && (bottom[i] < Y_MAX11);
      at_miss[i]   = active[i] && (bottom[i] >= Y_MAX11);
      if (in_window[i] && (!hit_found || (slot_y[i] > best_y))) begin
        hit_found = 1'b1;
        best_y    = slot_y[i];
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
      if (!active[i] && !free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
      end
    end
    if (!(key_ok && (state == S_RUN))) hit_oh = '0;
    miss_mask = at_miss & ~hit_oh;
    any_miss  = |miss_mask;
    spawn_due = (state == S_RUN) && (spawned < NOTES8) && (period_cnt == '0) && free_found;
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state      <= S_IDLE;
      active     <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      hits       <= '0;
      combo      <= '0;
      done       <= 1'b0;
      delay_cnt  <= '0;
      period_cnt <= '0;
      spawned    <= '0;
      for (int i = 0; i < SLOTS; i++) slot_y[i] <= Y_INIT;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        S_IDLE: begin
          if (keycode == START_KEY) begin
            state      <= S_DELAY;
            hits       <= '0;
            combo      <= '0;
            spawned    <= '0;
            delay_cnt  <= '0;
            period_cnt <= '0;
            active     <= '0;
            for (int i = 0; i < SLOTS; i++) slot_y[i] <= Y_INIT;
          end
        end
        S_DELAY: begin
          if (delay_cnt == DELAY_LAST) state <= S_RUN;
          else                         delay_cnt <= delay_cnt + 16'd1;
        end
        S_RUN: begin
          // A slot freed this frame only becomes spawnable next frame.
          for (int i = 0; i < SLOTS; i++) begin
            if (hit_oh[i] || miss_mask[i]) begin
              active[i] <= 1'b0;
              slot_y[i] <= Y_INIT;
            end else if (active[i]) begin
              slot_y[i] <= 10'({1'b0, slot_y[i]} + SPEED11);
            end else if (spawn_due && free_oh[i]) begin
              active[i] <= 1'b1;
              slot_y[i] <= Y_INIT;
            end
          end
          if (|hit_oh) begin
            hit <= 1'b1;
            if (hits != 8'hFF) hits <= hits + 8'd1;
          end
          if (any_miss) begin
            miss  <= 1'b1;
            combo <= '0;
          end else if ((|hit_oh) && (combo != 8'hFF)) begin
            combo <= combo + 8'd1;
          end
          // A due spawn with no free slot leaves the counter parked at zero.
          if (spawned < NOTES8) begin
            if (period_cnt != '0) begin
              period_cnt <= period_cnt - 16'd1;
            end else if (free_found) begin
              spawned    <= spawned + 8'd1;
              period_cnt <= PERIOD_RELOAD;
            end
          end else if (active == '0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (keycode == RESTART_KEY) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_dropper.sv
// Bench for lane_dropper: small chart (3 notes, 2 slots, 20-frame spawn period, 4-frame start delay).
// Hit/miss pulses are scored against an expected-event queue of {frame, hit, miss, hits, combo}.
module tb_lane_dropper;

  localparam int SLOTS        = 2;
  localparam int START_DELAY  = 4;
  localparam int SPAWN_PERIOD = 20;
  localparam int NUM_NOTES    = 3;
  localparam logic [9:0] Y0   = 10'd100;

  logic                frame_clk = 1'b0;
  logic                Reset = 1'b1;
  logic [7:0]          keycode = 8'h00;
  logic [7:0]          keycode_second = 8'h00;
  logic [9:0]          dropX;
  logic [10*SLOTS-1:0] dropY;
  logic [SLOTS-1:0]    active;
  logic                hit;
  logic                miss;
  logic [7:0]          hits;
  logic [7:0]          combo;
  logic                done;
  logic [1:0]          state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [33:0] exp_q[$];

  lane_dropper #(
    .START_DELAY (START_DELAY),
    .SPAWN_PERIOD(SPAWN_PERIOD),
    .NUM_NOTES   (NUM_NOTES),
    .SLOTS       (SLOTS)
  ) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .keycode       (keycode),
    .keycode_second(keycode_second),
    .dropX         (dropX),
    .dropY         (dropY),
    .active        (active),
    .hit           (hit),
    .miss          (miss),
    .hits          (hits),
    .combo         (combo),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  // clock / frame counter
  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;

  function automatic logic [33:0] ev(input int c, input logic h, input logic m, input int nh, input int nc);
    return {16'(c), h, m, 8'(nh), 8'(nc)};
  endfunction

  // Advance to frame 'target' (sampled on negedges), scoring every hit/miss pulse.
  task automatic run_to(input int target);
    logic [33:0] got;
    logic [33:0] want;
    while (cyc < target) begin
      @(negedge frame_clk);
      if (hit || miss) begin
        got = {16'(cyc), hit, miss, hits, combo};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected got=%h exp=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event got=%h exp=%h (frame,hit,miss,hits,combo)", got, want);
          end
        end
      end
    end
  endtask

  task automatic start_chart(output int s);
    keycode = 8'h2c;
    run_to(cyc + 1);
    keycode = 8'h00;
    s = cyc + START_DELAY + 2;
  endtask

  task automatic press_restart();
    keycode = 8'h01;
    run_to(cyc + 1);
    keycode = 8'h00;
  endtask

  task automatic press_key(input int e, input logic second);
    run_to(e - 1);
    if (second) keycode_second = 8'h07;
    else        keycode = 8'h07;
    run_to(e);
    keycode = 8'h00;
    keycode_second = 8'h00;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    #2;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    checks++; if (active !== 2'b00) begin errors++; $display("FAIL rst_active got=%b exp=00", active); end
    checks++; if (dropY !== {Y0, Y0}) begin errors++; $display("FAIL rst_dropY got=%h exp=%h", dropY, {Y0, Y0}); end
    checks++; if ({hit, miss, done} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b exp=000", {hit, miss, done}); end
    checks++; if ({hits, combo} !== 16'h0) begin errors++; $display("FAIL rst_counts got=%h exp=0000", {hits, combo}); end
    checks++; if (dropX !== 10'd160) begin errors++; $display("FAIL rst_dropX got=%0d exp=160", dropX); end
    repeat (3) @(negedge frame_clk);
    Reset = 1'b1;
    run_to(cyc + 2);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_idle_hold got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_miss_path();
    int s;
    start_chart(s);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL b_delay got=%0d exp=1", state_dbg); end
    exp_q.push_back(ev(s + 261, 1'b0, 1'b1, 0, 0));
    exp_q.push_back(ev(s + 281, 1'b0, 1'b1, 0, 0));
    exp_q.push_back(ev(s + 523, 1'b0, 1'b1, 0, 0));
    run_to(s - 2);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL b_delay_end got=%0d exp=1", state_dbg); end
    run_to(s - 1);
    checks++; if ({state_dbg, active} !== 4'b1000) begin errors++; $display("FAIL b_run_entry got=%b exp=1000", {state_dbg, active}); end
    run_to(s);
    checks++; if (active !== 2'b01 || dropY[9:0] !== Y0) begin errors++; $display("FAIL b_spawn0 got=%b/%0d exp=01/100", active, dropY[9:0]); end
    run_to(s + 20);
    checks++; if (active !== 2'b11 || dropY !== {Y0, 10'd120}) begin errors++; $display("FAIL b_spawn1 got=%b/%h exp=11/%h", active, dropY, {Y0, 10'd120}); end
    run_to(s + 261);
    checks++; if (active !== 2'b10) begin errors++; $display("FAIL b_retire0 got=%b exp=10", active); end
    run_to(s + 262);
    checks++; if (active !== 2'b11 || dropY[9:0] !== Y0) begin errors++; $display("FAIL b_deferred got=%b/%0d exp=11/100", active, dropY[9:0]); end
    run_to(s + 523);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b_done_early got=%b exp=0", done); end
    run_to(s + 524);
    checks++; if ({done, state_dbg} !== 3'b111) begin errors++; $display("FAIL b_done got=%b exp=111", {done, state_dbg}); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    press_restart();
    checks++; if ({done, state_dbg} !== 3'b000) begin errors++; $display("FAIL b_restart got=%b exp=000", {done, state_dbg}); end
  endtask

  task automatic test_hit_select();
    int s;
    start_chart(s);
    exp_q.push_back(ev(s + 231, 1'b1, 1'b0, 1, 1));
    exp_q.push_back(ev(s + 234, 1'b1, 1'b0, 2, 2));
    exp_q.push_back(ev(s + 493, 1'b0, 1'b1, 2, 0));
    press_key(s + 231, 1'b1);
    checks++; if (active !== 2'b10 || dropY[19:10] !== 10'd311) begin errors++; $display("FAIL c_deepest got=%b/%0d exp=10/311", active, dropY[19:10]); end
    run_to(s + 232);
    checks++; if (active !== 2'b11) begin errors++; $display("FAIL c_respawn got=%b exp=11", active); end
    press_key(s + 234, 1'b1);
    checks++; if (active !== 2'b01) begin errors++; $display("FAIL c_second got=%b exp=01", active); end
    run_to(s + 494);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL c_done got=%b exp=1", done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL c_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    press_restart();
  endtask

  task automatic test_held_key();
    int s;
    start_chart(s);
    exp_q.push_back(ev(s + 210, 1'b1, 1'b0, 1, 1));
`ifdef LANE_DROPPER_EDGE_HIT_EN
    exp_q.push_back(ev(s + 281, 1'b0, 1'b1, 1, 0));
    exp_q.push_back(ev(s + 472, 1'b0, 1'b1, 1, 0));
`else
    exp_q.push_back(ev(s + 221, 1'b1, 1'b0, 2, 2));
    exp_q.push_back(ev(s + 472, 1'b0, 1'b1, 2, 0));
`endif
    run_to(s + 209);
    keycode = 8'h07;
    run_to(s + 230);
    keycode = 8'h00;
    run_to(s + 473);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL d_done got=%b exp=1", done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL d_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    press_restart();
  endtask

  task automatic test_hit_and_miss();
    int s;
    start_chart(s);
    exp_q.push_back(ev(s + 261, 1'b1, 1'b1, 1, 0));
    exp_q.push_back(ev(s + 523, 1'b0, 1'b1, 1, 0));
    press_key(s + 261, 1'b0);
    checks++; if (active !== 2'b00) begin errors++; $display("FAIL e_both_retired got=%b exp=00", active); end
    run_to(s + 524);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL e_done got=%b exp=1", done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL e_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    press_restart();
  endtask

  task automatic test_reset_mid_run();
    int s;
    int t1;
    int t2;
    int lo;
    start_chart(s);
    t1 = s + int'($urandom_range(240, 201));
    lo = (t1 - s + 2 > 221) ? (t1 - s + 2) : 221;
    t2 = s + int'($urandom_range(280, lo));
    exp_q.push_back(ev(t1, 1'b1, 1'b0, 1, 1));
    exp_q.push_back(ev(t2, 1'b1, 1'b0, 2, 2));
    press_key(t1, 1'b0);
    press_key(t2, 1'b1);
    run_to(s + 300);
    checks++; if ({hits, combo} !== 16'h0202 || active !== 2'b01) begin errors++; $display("FAIL f_pre_reset got=%h/%b exp=0202/01", {hits, combo}, active); end
    #2 Reset = 1'b0;
    #1;
    checks++; if ({state_dbg, active, done} !== 5'b00000 || {hits, combo} !== 16'h0) begin errors++; $display("FAIL f_async got=%b/%h exp=00000/0000", {state_dbg, active, done}, {hits, combo}); end
    checks++; if (dropY !== {Y0, Y0}) begin errors++; $display("FAIL f_async_dropY got=%h exp=%h", dropY, {Y0, Y0}); end
    repeat (2) @(negedge frame_clk);
    Reset = 1'b1;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL f_pending got=%0d exp=0", exp_q.size()); exp_q.delete(); end
    start_chart(s);
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL f_restart_delay got=%0d exp=1", state_dbg); end
    run_to(s - 1);
    checks++; if (active !== 2'b00) begin errors++; $display("FAIL f_restart_early got=%b exp=00", active); end
    run_to(s);
    checks++; if (active !== 2'b01 || {hits, combo} !== 16'h0) begin errors++; $display("FAIL f_restart_spawn got=%b/%h exp=01/0000", active, {hits, combo}); end
  endtask

  initial begin
    test_reset();
    test_miss_path();
    test_hit_select();
    test_held_key();
    test_hit_and_miss();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_dropper.md
# lane_dropper

Parametrised multi-note lane engine for the rhythm game: one instance drives one key lane, spawning a chart of `NUM_NOTES` notes that fall from `Y_START` toward `Y_MAX`. It tracks up to `SLOTS` notes on screen at once, judges key hits inside the hit window, and reports hit/miss pulses plus hit and combo counts. It sits between the keyboard keycode path and the sprite renderer/score logic, one instance per lane.

## Interface
- `LANE_X`, 160, constant lane X position
- `KEYCODE`, 8'h07, lane key
- `START_KEY`, 8'h2c, start key; `RESTART_KEY`, 8'h01, return-to-idle key
- `Y_START`, 100, spawn Y; `Y_MAX`, 400, miss line (compared against note bottom); `NOTE_H`, 40, note height
- `HIT_LO`, 340, hit window lower bound on note bottom; window is [`HIT_LO`, `Y_MAX`)
- `SPEED`, 1, pixels per frame (1..15)
- `START_DELAY`, 760, frames between start and first spawn
- `SPAWN_PERIOD`, 120, frames between spawns (>=1)
- `NUM_NOTES`, 8, notes in the chart (1..255); `SLOTS`, 4, simultaneous notes (1..8)
- `frame_clk`  in  1  frame clock; the only clock
- `Reset`  in  1  asynchronous, active-low reset
- `keycode`, `keycode_second`  in  8 each  current pressed keycodes
- `dropX`  out  10  always `LANE_X`
- `dropY`  out  10*SLOTS  slot i Y at bits [10i+9:10i]
- `active`  out  SLOTS  slot i holds a falling note
- `hit`, `miss`  out  1 each  one-frame pulses
- `hits`, `combo`  out  8 each  total hits / current streak, saturating at 255
- `done`  out  1  chart finished

## Operation
- States: IDLE, DELAY, RUN, DONE. All outputs registered.
- IDLE: `START_KEY` on `keycode` -> DELAY; clears hits, combo, spawned count, slots, delay counter.
- DELAY: counts `START_DELAY` frames, then -> RUN. `START_DELAY`=0 enters RUN the next frame.
- RUN, each frame, evaluated on pre-update Y values:
  - Spawn: the first RUN frame spawns a note, then every `SPAWN_PERIOD` frames while spawned < `NUM_NOTES`. Spawn goes into the lowest-index free slot at `Y_START`. If no slot is free, the spawn is deferred and the period counter holds until a slot frees.
  - Hit: the lane key is on `keycode` or `keycode_second`, with press qualification per Configuration. Among active slots with bottom Y (Y+`NOTE_H`) in the window, the one with the largest Y retires; a tie goes to the lowest index. Effects: `hit`=1, hits+1, combo+1. At most one hit per frame.
  - Miss: each active slot not hit with Y+`NOTE_H` >= `Y_MAX` retires. Effects: `miss`=1 and combo=0.
  - Move: remaining active slots add `SPEED`.
  - Hit and miss in the same frame: both pulse, hits increments, combo ends at 0.
  - Spawned = `NUM_NOTES` and no slot active -> DONE. `done`=1 while in DONE.
- DONE: `RESTART_KEY` -> IDLE. Slots stay inactive.
- Arithmetic: all Y+`NOTE_H` and Y+`SPEED` sums use 11 bits, so no wrap. A retired slot's Y resets to `Y_START`.
- Any state with `Reset` low -> IDLE immediately, all registers at reset values. This includes reset mid-RUN.

## Timing
- Reset values: state IDLE, `dropY` all `Y_START`, `active`=0, `hit`=`miss`=0, `hits`=`combo`=0, `done`=0, key-history register 0. `dropX`=`LANE_X` always.
- Spawned slot: `active`=1 and `dropY`=`Y_START` after the spawning edge.
- Qualifying key frame -> `hit` high for exactly the following frame. Same for `miss`.
- SPEED=1 spawn-to-window: the note bottom reaches `HIT_LO` 200 frames after spawn; it misses at 260 frames (Y=360).

## Configuration
- `LANE_DROPPER_EDGE_HIT_EN` defined:
  - A hit needs a newly pressed lane key: key present now and absent on the previous frame, on either keycode input.
  - A held key scores at most one note.
- Undefined:
  - Level-sensitive judging: the key being present each frame qualifies.
  - A held key hits successive notes as they enter the window.

## Test plan
- START_DELAY=4, NUM_NOTES=1, no keys, 2c pressed -> spawn on frame 5 at Y=100, `miss` pulse when Y=360, combo=0, `done`=1 one frame later.
- Key 07 pressed for one frame when note Y=310 -> `hit`=1, hits=1, combo=1, slot inactive, no miss.
- SPAWN_PERIOD=20, SLOTS=2, two notes in window, key on `keycode_second` -> only the higher-Y note retires. A second press retires the other; combo=2.
- SLOTS=1, SPAWN_PERIOD=10 -> second spawn deferred until the first note retires, then spawns the same frame the slot frees plus one.
- EDGE_HIT_EN defined, key 07 held through two notes -> hits=1, then miss, combo=0. Undefined -> hits=2.
- Reset low mid-RUN with hits=3 -> all outputs at reset values asynchronously. After release, 2c restarts the chart from DELAY.
